// File: rtl/md_unit_pkg.sv
// Shared op codes and default latencies for the EX-stage multiply/divide unit.
package md_unit_pkg;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1a;
    localparam logic [5:0] OP_DIVU  = 6'h1b;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Codes that launch a multi-cycle operation.
    function automatic logic is_md_start(input logic [5:0] code);
        return (code == OP_MULT) || (code == OP_MULTU) || (code == OP_DIV) || (code == OP_DIVU);
    endfunction

    function automatic logic is_md(input logic [5:0] code);
        return is_md_start(code) || (code == OP_MFHI) || (code == OP_MTHI) ||
               (code == OP_MFLO) || (code == OP_MTLO);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy/countdown tracker for md_unit: loads N-1 on start, flags done on the last busy cycle.
module md_busy_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] load,
    output logic          busy,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            count <= load;
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == '0) busy <= 1'b0;
            else             count <= count - CW'(1);
        end
    end

    assign done = busy & (count == '0);

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into HI/LO, with stall back to ID/EX.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  ex_instr_code,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic        id_is_md,
    output logic [31:0] md_read_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        stall
);

    localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    logic          start, done;
    logic          is_div, sgn_mul, sgn_div, div_zero;
    logic [63:0]   mul_a, mul_b, prod;
    logic [31:0]   dvnd, dvsr_raw, dvsr, q_mag, r_mag, quot, rem;
    logic [31:0]   res_hi, res_lo;
    logic [31:0]   hi, lo, pending_hi, pending_lo;
    logic [CW-1:0] load_val;

    assign start = ~busy & is_md_start(ex_instr_code);
    assign is_div  = (ex_instr_code == OP_DIV) || (ex_instr_code == OP_DIVU);
    assign sgn_mul = (ex_instr_code == OP_MULT);
    assign sgn_div = (ex_instr_code == OP_DIV);

    // One shared 64-bit multiplier; signed mult just sign-extends the operands.
    assign mul_a = {{32{sgn_mul & ex_rs_data[31]}}, ex_rs_data};
    assign mul_b = {{32{sgn_mul & ex_rt_data[31]}}, ex_rt_data};
    assign prod  = mul_a * mul_b;

    // One unsigned divider on magnitudes; signs are restored afterwards.
    // Magnitude of 0x80000000 is 2^31 unsigned, so the overflow case lands on 0x80000000.
    assign div_zero = (ex_rt_data == 32'd0);
    assign dvnd     = (sgn_div & ex_rs_data[31]) ? -ex_rs_data : ex_rs_data;
    assign dvsr_raw = (sgn_div & ex_rt_data[31]) ? -ex_rt_data : ex_rt_data;
    assign dvsr     = div_zero ? 32'd1 : dvsr_raw;
    assign q_mag    = dvnd / dvsr;
    assign r_mag    = dvnd % dvsr;
    assign quot     = (sgn_div & (ex_rs_data[31] ^ ex_rt_data[31])) ? -q_mag : q_mag;
    assign rem      = (sgn_div & ex_rs_data[31]) ? -r_mag : r_mag;

    always_comb begin
        res_hi   = prod[63:32];
        res_lo   = prod[31:0];
        load_val = CW'(MULT_CYCLES - 1);
        if (is_div) begin
            load_val = CW'(DIV_CYCLES - 1);
            res_lo   = div_zero ? 32'hFFFF_FFFF : quot;
            res_hi   = div_zero ? ex_rs_data    : rem;
        end
    end

    md_busy_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .load  (load_val),
        .busy  (busy),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            if (start) begin
                pending_hi <= res_hi;
                pending_lo <= res_lo;
            end
            if (done) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end else if (!busy) begin
                if (ex_instr_code == OP_MTHI) hi <= ex_rs_data;
                if (ex_instr_code == OP_MTLO) lo <= ex_rs_data;
            end
        end
    end

    always_comb begin
        md_read_data = '0;
        if (ex_instr_code == OP_MFHI)      md_read_data = hi;
        else if (ex_instr_code == OP_MFLO) md_read_data = lo;
    end

    assign hi_out = hi;
    assign lo_out = lo;
    assign stall  = id_is_md & (busy | start);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed literal cases plus a random stall-honouring pipeline.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [5:0] NOP   = 6'h00;
    localparam logic [5:0] OTHER = 6'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  ex_code = NOP;
    logic [31:0] rs = '0, rt = '0;
    logic        id_is_md = 1'b0;
    logic [31:0] md_read_data, hi_out, lo_out;
    logic        busy, stall;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_instr_code (ex_code),
        .ex_rs_data    (rs),
        .ex_rt_data    (rt),
        .id_is_md      (id_is_md),
        .md_read_data  (md_read_data),
        .hi_out        (hi_out),
        .lo_out        (lo_out),
        .busy          (busy),
        .stall         (stall)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference state: architectural HI/LO, result waiting to land, cycles left busy.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_left = 0;
    bit          m_stall_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [5:0] code, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint p, q, r;
        longint unsigned pu;
        case (code)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: begin
                pu = 64'(a) * 64'(b);
                return pu;
            end
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic exp_stall();
        return id_is_md && ((m_left > 0) || is_md_start(ex_code));
    endfunction

    function automatic logic [31:0] exp_read();
        if (ex_code == OP_MFHI) return m_hi;
        if (ex_code == OP_MFLO) return m_lo;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        m_stall_prev = exp_stall();
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (is_md_start(ex_code)) begin
                checks++;
                errors++;
                $display("FAIL start_while_busy: code %h issued with %0d busy cycles left", ex_code, m_left);
            end
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (is_md_start(ex_code)) begin
            {m_phi, m_plo} = model_result(ex_code, rs, rt);
            m_left = (ex_code == OP_DIV || ex_code == OP_DIVU) ? DC : MC;
        end else if (ex_code == OP_MTHI) begin
            m_hi = rs;
        end else if (ex_code == OP_MTLO) begin
            m_lo = rs;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("hi_out", hi_out, m_hi);
            chk("lo_out", lo_out, m_lo);
            chk("md_read_data", md_read_data, exp_read());
            chk("stall", 32'(stall), 32'(exp_stall()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        int bc;
        n  = (code == OP_DIV || code == OP_DIVU) ? DC : MC;
        bc = 0;
        ex_code = code; rs = a; rt = b; id_is_md = 1'b0;
        step();
        ex_code = NOP;
        for (int i = 0; i < n; i++) begin
            if (busy) bc++;
            step();
        end
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(n));
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_hi"}, hi_out, eh);
        chk({nm, "_lo"}, lo_out, el);
        chk({nm, "_model_hi"}, m_hi, eh);
        chk({nm, "_model_lo"}, m_lo, el);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [5:0] rand_code();
        logic [5:0] codes [11] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO,
                                   OP_MTHI, OP_MTLO, NOP, OTHER, NOP};
        return codes[$urandom_range(0, 10)];
    endfunction

    initial begin
        logic [5:0] id_code;

        // Reset state
        step();
        chk_en = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b1;
        step();

        run_op("mult",      OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",     OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div",       OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",      OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op("divu_zero", OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFFD, 32'd0,         32'hFFFF_FFFD, 32'hFFFF_FFFF);

        // mult in EX with mflo waiting in ID
        ex_code = OP_MULT; rs = 32'd10; rt = 32'd20; id_is_md = 1'b1;
        #1;
        chk("stall_start", 32'(stall), 32'd1);
        step();
        ex_code = NOP;
        for (int i = 0; i < MC; i++) begin
            chk("stall_busy", 32'(stall), 32'd1);
            step();
        end
        chk("stall_after", 32'(stall), 32'd0);
        ex_code = OP_MFLO; id_is_md = 1'b0;
        #1;
        chk("mflo_new", md_read_data, 32'd200);
        step();

        // Non-MD in ID while busy never stalls
        ex_code = OP_MULTU; rs = 32'd4; rt = 32'd4; id_is_md = 1'b0;
        step();
        ex_code = NOP;
        for (int i = 0; i < MC; i++) begin
            chk("nomd_stall", 32'(stall), 32'd0);
            step();
        end

        // mthi / mtlo back to back
        ex_code = OP_MTHI; rs = 32'h1234_5678;
        step();
        chk("mthi", hi_out, 32'h1234_5678);
        ex_code = OP_MTLO; rs = 32'h9ABC_DEF0;
        step();
        chk("mtlo", lo_out, 32'h9ABC_DEF0);
        ex_code = OP_MFHI;
        #1;
        chk("mfhi_read", md_read_data, 32'h1234_5678);
        step();

        // Reset aborts a divide in flight
        ex_code = OP_DIV; rs = 32'd100; rt = 32'd3;
        step();
        ex_code = NOP;
        repeat (3) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        repeat (DC + 2) step();
        chk("abort_no_commit_hi", hi_out, 32'd0);
        chk("abort_no_commit_lo", lo_out, 32'd0);

        // Random program through an ID/EX stage that honours stall
        id_code = NOP;
        for (int c = 0; c < 3000; c++) begin
            if (m_stall_prev) begin
                ex_code = NOP;
            end else begin
                ex_code = id_code;
                rs      = rand_op();
                rt      = rand_op();
                id_code = rand_code();
            end
            id_is_md = is_md(id_code);
            reset    = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- EX-stage multiply/divide unit with HI/LO registers.
- Consumes the instruction code and operands held by the ID/EX pipeline register.
- Runs mult/multu/div/divu as fixed-latency multi-cycle operations.
- Drives the `stall` request back into the ID/EX register and hazard logic, so ID/EX inserts a nop while an MD result is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; registers clear on a clk edge with reset==0.
- ex_instr_code  input  6  instruction code from ID/EX (codes from instr.vh: mult, multu, div, divu, mfhi, mflo, mthi, mtlo; others ignored).
- ex_rs_data  input  32  forwarded rs operand in EX.
- ex_rt_data  input  32  forwarded rt operand in EX.
- id_is_md  input  1  instruction in ID is any of the 8 MD codes.
- md_read_data  output  32  hi for mfhi, lo for mflo, else 0; combinational from registers.
- hi_out  output  32  architectural HI.
- lo_out  output  32  architectural LO.
- busy  output  1  operation in progress.
- stall  output  1  stall request to ID/EX and PC/IF_ID.

Behaviour:
- Reset (edge with reset==0):
  - hi, lo, count, pending_hi, pending_lo = 0; busy = 0.
  - Aborts any operation in flight; no commit occurs.
- start = ~busy & ex_instr_code in {mult, multu, div, divu}.
- Operation issue and commit:
  - At the start edge: pending_hi/lo latch the full result, computed combinationally; busy <= 1; count <= N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - While busy: count decrements each edge. At the edge where count==0: hi <= pending_hi, lo <= pending_lo, busy <= 0.
  - busy is high for exactly N cycles after the start edge.
  - New hi/lo are visible in the first cycle busy is low.
- mult: {hi,lo} = signed 64-bit product. multu: unsigned product.
- div:
  - lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu): lo = 0xFFFFFFFF, hi = rs. Same latency; no exception.
- mthi/mtlo:
  - When ~busy: hi (or lo) <= ex_rs_data at the next edge.
  - When busy: ignored. This cannot happen when stall is honoured.
- MD start while busy: ignored. This cannot happen when stall is honoured; the bench flags it.
- stall = id_is_md & (busy | start), combinational.
  - Blocks the next MD instruction until the first cycle after commit.
  - The mfhi reaching EX therefore reads committed values; there is no hi/lo bypass.
- Non-MD instructions proceed freely while busy.
- Simultaneous events:
  - reset wins over commit and start.
  - A commit edge and a start edge never coincide, since start requires ~busy.
- md_read_data reflects registered hi/lo only.

Decomposition:
- Shared package/header constants: MD op codes (existing instr.vh), default latencies MULT_CYCLES/DIV_CYCLES (constant.vh).
- One sub-module, md_busy_counter:
  - Loads N-1 on start, decrements while busy.
  - Outputs busy and done (count==0 & busy).
- Arithmetic is inline combinational logic in md_unit.

Test Plan:
- mult rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9(-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0. divu 5/0 -> lo=0xFFFFFFFF, hi=5.
- mult in EX with mflo in ID -> stall=1 on the start cycle and all 5 busy cycles, 0 afterwards; mflo then returns the new lo. Non-MD in ID during busy -> stall=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on back-to-back cycles -> hi_out/lo_out update one edge later each; md_read_data for mfhi = 0x12345678.
- Start div, assert reset low at busy cycle 4 -> next edge busy=0, hi=lo=0, no later commit.
